// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel hobby-servo PWM generator.
// A shared free-running frame counter drives every channel. Each channel holds a
// target and a current position (degrees); the current position follows the
// target once per frame, optionally slew-limited. Pulses are staggered by
// channel index so servo inrush currents do not coincide.
// Width, enable and position only change at the frame boundary, so every pulse
// emitted is a complete, legal width.
module servo_pwm_multi #(
  parameter int N_CH          = 4,
  parameter int FRAME_TICKS   = 200000,
  parameter int MIN_TICKS     = 5000,
  parameter int STEP_TICKS    = 111,
  parameter int MAX_DEG       = 180,
  parameter int SLEW_DEG      = 0,
  parameter int STAGGER_TICKS = 25000
) (
  input  logic            clk_10MHz,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [3:0]      wr_ch,
  input  logic [7:0]      wr_pos,
  input  logic [N_CH-1:0] ch_en,
  output logic [N_CH-1:0] servo_pwm,
  output logic            frame_start,
  output logic [N_CH-1:0] busy
);

  localparam int            CW        = $clog2(FRAME_TICKS);
  localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_TICKS - 1);
  localparam logic [7:0]    MAX_POS   = 8'(MAX_DEG);
  localparam logic [7:0]    SLEW      = 8'(SLEW_DEG);
  localparam logic [7:0]    RST_POS   = 8'd90;
  localparam logic [CW-1:0] RST_WIDTH = CW'(MIN_TICKS + 90 * STEP_TICKS);
  localparam logic [CW-1:0] MIN_W     = CW'(MIN_TICKS);
  localparam logic [CW-1:0] STEP_W    = CW'(STEP_TICKS);

  logic [CW-1:0]   r_cnt;
  logic            r_frame_start;
  logic [7:0]      r_tgt   [N_CH];
  logic [7:0]      r_cur   [N_CH];
  logic [CW-1:0]   r_width [N_CH];
  logic [N_CH-1:0] r_en_lat;
  logic [N_CH-1:0] r_pwm;

  logic            w_boundary;
  logic [7:0]      w_wr_pos_clamped;
  logic [7:0]      w_diff       [N_CH];
  logic [7:0]      w_next_cur   [N_CH];
  logic [CW-1:0]   w_next_width [N_CH];
  logic [CW:0]     w_off        [N_CH];
  logic [N_CH-1:0] w_pwm_next;
  logic [N_CH-1:0] w_busy;

  assign w_boundary       = (r_cnt == LAST_CNT);
  assign w_wr_pos_clamped = (wr_pos > MAX_POS) ? MAX_POS : wr_pos;

  // Frame counter: free-running 0..FRAME_TICKS-1; frame_start marks the cycle after cnt==0.
  always_ff @(posedge clk_10MHz) begin
    if (reset) begin
      r_cnt         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt         <= w_boundary ? '0 : r_cnt + CW'(1);
      r_frame_start <= (r_cnt == '0);
    end
  end

  // Next position per channel: jump to target, or step by SLEW toward it when far away.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      w_diff[k]     = (r_tgt[k] >= r_cur[k]) ? (r_tgt[k] - r_cur[k]) : (r_cur[k] - r_tgt[k]);
      w_next_cur[k] = r_tgt[k];
      if ((SLEW != 8'd0) && (w_diff[k] > SLEW)) begin
        if (r_tgt[k] > r_cur[k]) begin
          w_next_cur[k] = r_cur[k] + SLEW;
        end else begin
          w_next_cur[k] = r_cur[k] - SLEW;
        end
      end
      w_next_width[k] = MIN_W + CW'(w_next_cur[k]) * STEP_W;
    end
  end

  // Target writes land any cycle; the boundary update reads the pre-write target.
  always_ff @(posedge clk_10MHz) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        r_tgt[k] <= RST_POS;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (wr_en && (wr_ch == 4'(k))) begin
          r_tgt[k] <= w_wr_pos_clamped;
        end
      end
    end
  end

  // Frame-boundary latch of position, pulse width and enable (keeps pulses glitch-free).
  always_ff @(posedge clk_10MHz) begin
    if (reset) begin
      r_en_lat <= '0;
      for (int k = 0; k < N_CH; k++) begin
        r_cur[k]   <= RST_POS;
        r_width[k] <= RST_WIDTH;
      end
    end else if (w_boundary) begin
      r_en_lat <= ch_en;
      for (int k = 0; k < N_CH; k++) begin
        r_cur[k]   <= w_next_cur[k];
        r_width[k] <= w_next_width[k];
      end
    end
  end

  // Pulse window per channel: [k*STAGGER, k*STAGGER + width), one extra bit avoids wrap.
  always_comb begin
    w_pwm_next = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_off[k]      = (CW+1)'(k * STAGGER_TICKS);
      w_pwm_next[k] = r_en_lat[k]
                      && ({1'b0, r_cnt} >= w_off[k])
                      && ({1'b0, r_cnt} < (w_off[k] + {1'b0, r_width[k]}));
    end
  end

  // Registered PWM outputs.
  always_ff @(posedge clk_10MHz) begin
    if (reset) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_pwm_next;
    end
  end

  // Busy while a channel has not yet reached its target.
  always_comb begin
    w_busy = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_busy[k] = (r_cur[k] != r_tgt[k]);
    end
  end

  assign servo_pwm   = r_pwm;
  assign frame_start = r_frame_start;
  assign busy        = w_busy;

endmodule

// File: doc/servo_pwm_multi.md
# servo_pwm_multi

Parametrised N-channel servo PWM generator, successor to the single-channel 7-angle servo driver. It produces one hobby-servo pulse per channel per frame from a shared frame counter. Each channel takes a 1-degree-resolution target position, moves toward it with optional per-frame slew limiting, and emits its pulse at a staggered offset within the frame to spread servo inrush current. It sits between the board control logic (switch/UART decoders) and the servo header pins.

## Interface
- N_CH, 4: number of servo channels (1..16)
- FRAME_TICKS, 200000: frame period in clock cycles (20 ms at 10 MHz)
- MIN_TICKS, 5000: pulse width at 0 deg (0.5 ms)
- STEP_TICKS, 111: added pulse width per degree (180 deg gives 24980 ticks, about 2.5 ms)
- MAX_DEG, 180: position clamp value
- SLEW_DEG, 0: maximum change in degrees per frame; 0 means an immediate jump
- STAGGER_TICKS, 25000: pulse start offset between adjacent channels; must satisfy STAGGER_TICKS*(N_CH-1) + MIN_TICKS + MAX_DEG*STEP_TICKS < FRAME_TICKS

Ports (clock and reset first):
- clk_10MHz  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  target write strobe, one cycle per write
- wr_ch  in  4  channel index for the write
- wr_pos  in  8  target position in degrees
- ch_en  in  N_CH  per-channel output enable
- servo_pwm  out  N_CH  registered PWM outputs
- frame_start  out  1  one-cycle pulse at frame start
- busy  out  N_CH  bit k set while cur[k] != tgt[k]

## Operation
- Frame counter cnt:
  - Width is clog2(FRAME_TICKS).
  - Counts 0..FRAME_TICKS-1, then wraps to 0. It runs free and never stops.
- Per-channel registers:
  - tgt[k] and cur[k] are 8 bits each.
  - en_lat[k] is 1 bit.
  - width[k] has the same width as cnt.
- Write path:
  - When wr_en=1 and wr_ch < N_CH, tgt[wr_ch] <= min(wr_pos, MAX_DEG).
  - A write with wr_ch >= N_CH is ignored.
  - A write never alters cur, width or en_lat directly.
- Frame boundary update, in the cycle where cnt==FRAME_TICKS-1, for every k:
  - If SLEW_DEG==0, or |tgt-cur| <= SLEW_DEG: cur <= tgt.
  - Otherwise: cur <= cur ± SLEW_DEG, moving toward tgt.
  - width[k] <= MIN_TICKS + next_cur[k]*STEP_TICKS.
  - en_lat[k] <= ch_en[k].
  - Slewing continues whether or not the channel is enabled.
- Pulse generation:
  - Channel k has offset off_k = k*STAGGER_TICKS.
  - servo_pwm[k] is registered: next value = en_lat[k] && cnt >= off_k && cnt < off_k + width[k].
- Glitch-free rule: a pulse width or enable change never takes effect mid-frame. Every pulse is a full, legal width.
- busy is combinational from cur/tgt.

## Timing
- Reset values:
  - cnt=0, tgt=cur=90.
  - width = MIN_TICKS + 90*STEP_TICKS.
  - en_lat=0, servo_pwm=0, frame_start=0, busy=0.
- First frame after reset: cnt=0 in the first cycle after reset deasserts.
- frame_start is registered and high for one cycle, in the cycle after cnt==0.
- Pulse latency: servo_pwm[k] rises one cycle after cnt==off_k and stays high exactly width[k] cycles.
- Write-to-output latency: the target is visible on tgt the next cycle. It affects the pulse at the next frame boundary, or gradually if slew-limited.
- Write in the same cycle as the boundary update: the update uses the old tgt. The new tgt is applied at the following boundary.
- ch_en changes mid-frame are ignored until the next boundary.
- Reset mid-pulse: servo_pwm drops to 0 the cycle after reset is sampled. All state returns to reset values.
- Arithmetic:
  - |tgt-cur| is computed as an unsigned 8-bit difference.
  - The width product is sized so that MAX_DEG*STEP_TICKS + MIN_TICKS fits the cnt width without overflow.

## Test plan
- Reset, then ch_en=4'b0001 with no writes:
  - servo_pwm[0] pulses 14990 cycles every 200000 cycles, starting at frame 2 (enable is latched at the first boundary).
  - servo_pwm[3:1] stay 0.
- Writes with ch_en=4'hF, SLEW_DEG=0:
  - Stimulus: ch0=0, ch1=180, ch2=200, ch3=45.
  - Widths next frame: 5000, 24980, 24980 (clamped), 9995.
  - Rising edges at cnt+1 = 0, 25000, 50000, 75000.
- Slew test with SLEW_DEG=10:
  - Stimulus: write ch0 from 90 to 0.
  - cur[0] steps 80, 70, ..., 0 over 9 frames.
  - busy[0]=1 until the boundary that reaches 0, then 0.
  - Every pulse width is MIN_TICKS + cur*111.
- Mid-frame write while servo_pwm[1] is high:
  - The current pulse keeps its old width.
  - The new width appears from the next frame.
  - A write coincident with cnt==FRAME_TICKS-1 is deferred one frame.
- wr_ch=5 with N_CH=4: no tgt register changes and busy stays 0.
- Reset asserted mid-pulse: servo_pwm=0 the next cycle; cnt, tgt, cur and width return to reset values.
